// File: rtl/shape_layers.sv
// Prioritised solid-colour rectangle compositor over the LCD timing counters.
// Double-buffered config applied at frame start; optional per-frame edge bounce.
module shape_layers #(
   parameter int unsigned N_RECTS  = 4,
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter logic [15:0] BG_COLOR = 16'h0000,
   parameter int unsigned AW       = $clog2(N_RECTS) + 3
) (
   input  logic          PixelClk,
   input  logic          Reset,
   input  logic [15:0]   PixelCount,
   input  logic [15:0]   LineCount,
   input  logic          InDE,
   input  logic          cfg_wr,
   input  logic [AW-1:0] cfg_addr,
   input  logic [15:0]   cfg_data,
   input  logic          cfg_commit,
   output logic          cfg_pending,
   output logic          LCD_DE,
   output logic [4:0]    LCD_R,
   output logic [5:0]    LCD_G,
   output logic [4:0]    LCD_B
);

   typedef struct packed {
      logic [15:0] left;
      logic [15:0] right;
      logic [15:0] top;
      logic [15:0] bottom;
      logic [15:0] color;
      logic        en;
      logic        bounce;
      logic [7:0]  dy;
      logic [7:0]  dx;
   } rect_t;

   typedef enum logic {StIdle, StPending} state_e;

   localparam logic signed [16:0] XMax = 17'(H_ACTIVE - 1);
   localparam logic signed [16:0] YMax = 17'(V_ACTIVE - 1);

   state_e         state_q, state_d;
   rect_t          shd_q [N_RECTS];
   rect_t          shd_d [N_RECTS];
   rect_t          act_q [N_RECTS];
   rect_t          act_d [N_RECTS];
   logic [15:0]    px_q, px_d, py_q, py_d;
   logic           de1_q, de1_d, de2_q, de2_d;
   logic [15:0]    rgb_q, rgb_d;
   logic [15:0]    hit_color;
   logic           frame_start, do_copy;
   logic [AW-1:0]  wr_idx;
   logic [2:0]     wr_fld;
   logic signed [16:0] lo_n, hi_n;

   function automatic logic [7:0] neg8(input logic [7:0] v);
      return (v == 8'h80) ? 8'h7F : 8'(-v);
   endfunction

   assign frame_start = (PixelCount == 16'd0) && (LineCount == 16'd0);
   // A commit arriving on the frame-start cycle itself is honoured immediately.
   assign do_copy     = frame_start && ((state_q == StPending) || cfg_commit);
   assign wr_idx      = cfg_addr >> 3;
   assign wr_fld      = cfg_addr[2:0];

   always_comb begin
      state_d = state_q;
      if (do_copy) begin
         state_d = StIdle;
      end else if (cfg_commit) begin
         state_d = StPending;
      end
   end

   always_comb begin
      for (int i = 0; i < N_RECTS; i++) begin
         shd_d[i] = shd_q[i];
         if (cfg_wr && (wr_idx == AW'(i))) begin
            case (wr_fld)
               3'd0: shd_d[i].left   = cfg_data;
               3'd1: shd_d[i].right  = cfg_data;
               3'd2: shd_d[i].top    = cfg_data;
               3'd3: shd_d[i].bottom = cfg_data;
               3'd4: shd_d[i].color  = cfg_data;
               3'd5: begin
                  shd_d[i].en     = cfg_data[0];
                  shd_d[i].bounce = cfg_data[1];
               end
               3'd6: begin
                  shd_d[i].dx = cfg_data[7:0];
                  shd_d[i].dy = cfg_data[15:8];
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      lo_n = '0;
      hi_n = '0;
      for (int i = 0; i < N_RECTS; i++) begin
         act_d[i] = act_q[i];
         if (do_copy) begin
            act_d[i] = shd_q[i];
         end else if (frame_start && act_q[i].en && act_q[i].bounce) begin
            lo_n = $signed({1'b0, act_q[i].left}) + $signed({{9{act_q[i].dx[7]}}, act_q[i].dx});
            hi_n = $signed({1'b0, act_q[i].right}) + $signed({{9{act_q[i].dx[7]}}, act_q[i].dx});
            if (lo_n[16] || (hi_n > XMax)) begin
               act_d[i].dx = neg8(act_q[i].dx);
            end else begin
               act_d[i].left  = lo_n[15:0];
               act_d[i].right = hi_n[15:0];
            end
            lo_n = $signed({1'b0, act_q[i].top}) + $signed({{9{act_q[i].dy[7]}}, act_q[i].dy});
            hi_n = $signed({1'b0, act_q[i].bottom}) + $signed({{9{act_q[i].dy[7]}}, act_q[i].dy});
            if (lo_n[16] || (hi_n > YMax)) begin
               act_d[i].dy = neg8(act_q[i].dy);
            end else begin
               act_d[i].top    = lo_n[15:0];
               act_d[i].bottom = hi_n[15:0];
            end
         end
      end
   end

   // Stage 1 holds the counters; the hit test reads the already-updated active set.
   always_comb begin
      px_d      = PixelCount;
      py_d      = LineCount;
      de1_d     = InDE;
      hit_color = BG_COLOR;
      for (int i = int'(N_RECTS) - 1; i >= 0; i--) begin
         if (act_q[i].en && (act_q[i].left <= px_q) && (px_q <= act_q[i].right) &&
             (act_q[i].top <= py_q) && (py_q <= act_q[i].bottom)) begin
            hit_color = act_q[i].color;
         end
      end
      de2_d = de1_q;
      rgb_d = de1_q ? hit_color : 16'h0000;
   end

   always_ff @(posedge PixelClk) begin
      if (Reset) begin
         state_q <= StIdle;
         px_q    <= '0;
         py_q    <= '0;
         de1_q   <= 1'b0;
         de2_q   <= 1'b0;
         rgb_q   <= '0;
         for (int i = 0; i < N_RECTS; i++) begin
            shd_q[i] <= '0;
            act_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         de1_q   <= de1_d;
         de2_q   <= de2_d;
         rgb_q   <= rgb_d;
         for (int i = 0; i < N_RECTS; i++) begin
            shd_q[i] <= shd_d[i];
            act_q[i] <= act_d[i];
         end
      end
   end

   assign cfg_pending = (state_q == StPending);
   assign LCD_DE      = de2_q;
   assign LCD_R       = rgb_q[15:11];
   assign LCD_G       = rgb_q[10:5];
   assign LCD_B       = rgb_q[4:0];

endmodule

// File: doc/shape_layers.md
# shape_layers

Parametrised rectangle compositor for the LCD test pattern path. It takes the panel timing counters and draws up to N_RECTS runtime-programmable, prioritised, solid-colour rectangles over a background colour, driving the RGB565 LCD pins.
- Configuration is double-buffered: writes go to shadow registers and are applied at frame start, so an update never tears mid-frame.
- Each rectangle can bounce autonomously off the active-area edges, one velocity step per frame.

## Interface
- N_RECTS, 4: number of rectangles, 1..16; index 0 has the highest priority.
- H_ACTIVE, 800: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- BG_COLOR, 16'h0000: RGB565 colour used inside DE when no rectangle hits.
- AW, $clog2(N_RECTS)+3: config address width, derived.

Ports:
- PixelClk  in  1  pixel clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- PixelCount  in  16  current pixel x from the timing generator.
- LineCount  in  16  current line y from the timing generator.
- InDE  in  1  data enable aligned with the counters.
- cfg_wr  in  1  shadow register write strobe.
- cfg_addr  in  AW  {rect_index, field[2:0]}.
- cfg_data  in  16  write data.
- cfg_commit  in  1  request to copy shadow to active at the next frame start.
- cfg_pending  out  1  commit requested but not yet applied.
- LCD_DE  out  1  InDE delayed to match the colour pipeline.
- LCD_R  out  5  red.
- LCD_G  out  6  green.
- LCD_B  out  5  blue.

## Operation
- Fields per rectangle:
  - 0 left, 1 right, 2 top, 3 bottom (unsigned, inclusive bounds).
  - 4 colour (RGB565).
  - 5 ctrl: bit0 enable, bit1 bounce_en.
  - 6 velocity: [7:0] dx, [15:8] dy, both signed 8-bit.
  - 7 reserved.
- Writes to field 7, or to a rect_index >= N_RECTS, are ignored.
- Hit test: enable & left<=x<=right & top<=y<=bottom. If left>right or top>bottom, the rectangle never hits.
- Priority: the lowest-index hitting rectangle supplies the colour. With no hit, BG_COLOR is output. When the delayed DE is 0, RGB is 0.
- Frame start is the cycle where PixelCount==0 and LineCount==0.
- Commit (two-state FSM, IDLE/PENDING):
  - cfg_commit moves IDLE to PENDING and sets cfg_pending=1.
  - A frame start while in PENDING copies all shadow registers to active, returns to IDLE, and clears cfg_pending on the next cycle.
  - cfg_commit asserted in the same cycle as a frame start is applied in that frame start.
  - A cfg_wr in the same cycle as a frame-start copy lands in shadow only and is not included in that copy.
  - Further cfg_commit pulses while PENDING have no extra effect.
- Bounce: at a frame start with no copy, each rectangle with enable & bounce_en is updated per axis. Arithmetic is 17-bit signed with sign-extended dx/dy.
  - X axis: if left+dx<0 or right+dx>H_ACTIVE-1, set dx <= -dx and leave the x bounds unchanged. Otherwise left += dx and right += dx.
  - Y axis: the same rule using top/bottom, dy and V_ACTIVE-1.
  - Reversing -128 yields +127 (saturating).
  - Bounce modifies active registers only; shadow is untouched.
- On a frame start where a copy occurs, no bounce step is applied.

## Timing
- Pipeline latency is 2 PixelClk cycles:
  - Stage 1 registers PixelCount, LineCount and InDE.
  - Stage 2 registers the hit/priority result into LCD_* and LCD_DE.
- An active-register change at a frame start affects pixels from that same frame-start pixel onward, because stage 1 compares against the post-update active set.
- Reset, which overrides all other inputs:
  - LCD_R/G/B=0, LCD_DE=0, cfg_pending=0, FSM=IDLE.
  - All shadow and active fields are 0 (all rectangles disabled).
  - Both pipeline stages are cleared.
- Reset asserted mid-frame: outputs read 0 on the cycle after Reset is sampled high. A pending commit is discarded.

## Test plan
- Reset mid-frame: Reset high for 1 cycle -> LCD_DE and RGB read 0 on the next cycle, cfg_pending=0, and no rectangle is drawn afterwards.
- Single rectangle: rect0 = 200..400 x 100..400, colour 16'h07E0, enable, commit -> from the next frame, LCD_G=6'h3F exactly for those pixels with a 2-cycle lag. All other DE pixels show BG, and RGB=0 outside DE.
- Priority: rect0 = 10..20 x 10..20 colour F800, rect1 = 15..30 x 15..30 colour 001F -> pixel (18,18) is F800 and pixel (25,25) is 001F.
- Tear-free update: rewrite rect0 left=300 mid-frame without commit -> no change. Then commit mid-frame -> cfg_pending=1 until the next frame start, and the new bounds apply from that frame only.
- Bounce: rect0 left=795, right=799, dx=+3, bounce_en -> next frame dx=-3 with bounds unchanged, then the following frame left=792. Also dx=-128 at left=0 reverses to +127.
- Edge cases:
  - Write to field 7 or to rect_index N_RECTS -> no visible effect.
  - cfg_commit coincident with frame start -> applied that frame, with cfg_pending low by the next cycle.
  - cfg_wr coincident with the copy -> that write is excluded from the copy.
